// File: rtl/rs_ula_pkg.sv
// rs_ula_pkg -- shared definitions for the ULA reservation station.
// Holds the operation encodings, the per-entry state encoding, the bit
// positions of the common data bus fields and the unit bit that marks
// a ULA result, plus helpers that split a CDB word into tag and data.
package rs_ula_pkg;

    localparam int NUM_ENTRIES = 4;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    // Highest destination register this unit may write (R0..R2).
    localparam logic [2:0] DEST_MAX = 3'b010;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } entry_state_e;

    // CDB layout: [15:13] one-hot dest, [12:11] RS position, [10] unit, [9:0] data.
    localparam int CDB_DEST_MSB = 15;
    localparam int CDB_DEST_LSB = 13;
    localparam int CDB_POS_MSB  = 12;
    localparam int CDB_POS_LSB  = 11;
    localparam int CDB_UNIT_BIT = 10;
    localparam int CDB_DATA_MSB = 9;
    localparam int CDB_DATA_LSB = 0;

    localparam logic UNIT_ULA = 1'b1;

    // Producer tag carried by a broadcast: {unit bit, RS position}.
    function automatic logic [2:0] cdb_tag(input logic [15:0] cdb);
        return {cdb[CDB_UNIT_BIT], cdb[CDB_POS_MSB:CDB_POS_LSB]};
    endfunction

    // Broadcast payload, zero-extended to the 16-bit operand width.
    function automatic logic [15:0] cdb_data(input logic [15:0] cdb);
        return {6'b000000, cdb[CDB_DATA_MSB:CDB_DATA_LSB]};
    endfunction

endpackage

// File: rtl/rs_ula_entry.sv
// rs_ula_entry -- one reservation-station slot.
// Holds the slot state (FREE/WAIT/READY/EXEC), the operation, destination,
// both operand values and their pending tags. Snoops the CDB to capture
// operands (including at issue time) and to release itself once the ULA
// broadcasts its own result.
// Ports:
//   clock, reset_n        clock and synchronous active-low reset
//   alloc, alloc_*        write this slot with the instruction being issued
//   cdb_valid, cdb_tag_in, cdb_data_in   decoded common data bus
//   dispatch              this slot was selected for dispatch this cycle
//   state_o, op_o, dest_o, vj_o, vk_o    slot contents for the top level
module rs_ula_entry
    import rs_ula_pkg::*;
#(
    parameter logic [1:0] IDX = 2'd0
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        alloc,
    input  logic [2:0]  alloc_op,
    input  logic [2:0]  alloc_dest,
    input  logic        alloc_qj_wait,
    input  logic [2:0]  alloc_qj,
    input  logic [15:0] alloc_vj,
    input  logic        alloc_qk_wait,
    input  logic [2:0]  alloc_qk,
    input  logic [15:0] alloc_vk,
    input  logic        cdb_valid,
    input  logic [2:0]  cdb_tag_in,
    input  logic [15:0] cdb_data_in,
    input  logic        dispatch,
    output logic [1:0]  state_o,
    output logic [2:0]  op_o,
    output logic [2:0]  dest_o,
    output logic [15:0] vj_o,
    output logic [15:0] vk_o
);

    entry_state_e state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [2:0]   dest_q, dest_d;
    logic         qj_wait_q, qj_wait_d;
    logic [2:0]   qj_q, qj_d;
    logic [15:0]  vj_q, vj_d;
    logic         qk_wait_q, qk_wait_d;
    logic [2:0]   qk_q, qk_d;
    logic [15:0]  vk_q, vk_d;
    logic         free_hit;

    // Only a ULA result tagged with this slot's own position releases it.
    assign free_hit = cdb_valid && (cdb_tag_in == {UNIT_ULA, IDX});

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_FREE;
            op_q      <= 3'b000;
            dest_q    <= 3'b000;
            qj_wait_q <= 1'b0;
            qj_q      <= 3'b000;
            vj_q      <= 16'h0000;
            qk_wait_q <= 1'b0;
            qk_q      <= 3'b000;
            vk_q      <= 16'h0000;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dest_q    <= dest_d;
            qj_wait_q <= qj_wait_d;
            qj_q      <= qj_d;
            vj_q      <= vj_d;
            qk_wait_q <= qk_wait_d;
            qk_q      <= qk_d;
            vk_q      <= vk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dest_d    = dest_q;
        qj_wait_d = qj_wait_q;
        qj_d      = qj_q;
        vj_d      = vj_q;
        qk_wait_d = qk_wait_q;
        qk_d      = qk_q;
        vk_d      = vk_q;
        case (state_q)
            ST_FREE: begin
                if (alloc) begin
                    op_d      = alloc_op;
                    dest_d    = alloc_dest;
                    qj_d      = alloc_qj;
                    qk_d      = alloc_qk;
                    vj_d      = alloc_vj;
                    vk_d      = alloc_vk;
                    qj_wait_d = alloc_qj_wait;
                    qk_wait_d = alloc_qk_wait;
                    // A producer broadcasting in the issue cycle would
                    // otherwise be missed forever, so capture it here.
                    if (alloc_qj_wait && cdb_valid && (alloc_qj == cdb_tag_in)) begin
                        vj_d      = cdb_data_in;
                        qj_wait_d = 1'b0;
                    end
                    if (alloc_qk_wait && cdb_valid && (alloc_qk == cdb_tag_in)) begin
                        vk_d      = cdb_data_in;
                        qk_wait_d = 1'b0;
                    end
                    state_d = (qj_wait_d || qk_wait_d) ? ST_WAIT : ST_READY;
                end
            end
            ST_WAIT: begin
                if (qj_wait_q && cdb_valid && (qj_q == cdb_tag_in)) begin
                    vj_d      = cdb_data_in;
                    qj_wait_d = 1'b0;
                end
                if (qk_wait_q && cdb_valid && (qk_q == cdb_tag_in)) begin
                    vk_d      = cdb_data_in;
                    qk_wait_d = 1'b0;
                end
                if (!qj_wait_d && !qk_wait_d) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (dispatch) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (free_hit) begin
                    state_d = ST_FREE;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_comb begin
        state_o = state_q;
        op_o    = op_q;
        dest_o  = dest_q;
        vj_o    = vj_q;
        vk_o    = vk_q;
    end

endmodule

// File: rtl/rs_ula.sv
// rs_ula -- four-entry reservation station feeding the ULA (ADD/SUB).
// Accepts one instruction per cycle into the lowest free slot, lets slots
// wake up from the common data bus and dispatches the lowest-index READY
// slot each cycle through a registered operand interface.
// Ports:
//   clock, reset_n                    clock, synchronous active-low reset
//   issue_valid/ready/pos             issue handshake and allocated tag
//   issue_op/dest/qj*/vj/qk*/vk       instruction fields
//   cdb, cdb_valid                    common data bus
//   RY_data, RZ_data, reg_dest, ULA_op, RS_position, operands_ready
//                                     registered dispatch to the ULA
module rs_ula
    import rs_ula_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    output logic [1:0]  issue_pos,
    input  logic [2:0]  issue_op,
    input  logic [2:0]  issue_dest,
    input  logic        issue_qj_wait,
    input  logic [2:0]  issue_qj,
    input  logic [15:0] issue_vj,
    input  logic        issue_qk_wait,
    input  logic [2:0]  issue_qk,
    input  logic [15:0] issue_vk,
    input  logic [15:0] cdb,
    input  logic        cdb_valid,
    output logic [15:0] RY_data,
    output logic [15:0] RZ_data,
    output logic [2:0]  reg_dest,
    output logic [2:0]  ULA_op,
    output logic [1:0]  RS_position,
    output logic        operands_ready
);

    logic [1:0]  ent_state [NUM_ENTRIES];
    logic [2:0]  ent_op    [NUM_ENTRIES];
    logic [2:0]  ent_dest  [NUM_ENTRIES];
    logic [15:0] ent_vj    [NUM_ENTRIES];
    logic [15:0] ent_vk    [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] free_vec;
    logic [NUM_ENTRIES-1:0] ready_vec;
    logic [NUM_ENTRIES-1:0] alloc_vec;
    logic [NUM_ENTRIES-1:0] disp_vec;

    logic        issue_legal;
    logic        issue_accept;
    logic        any_ready;
    logic [1:0]  disp_idx;
    logic [2:0]  bus_tag;
    logic [15:0] bus_data;

    logic [15:0] ry_q, ry_d;
    logic [15:0] rz_q, rz_d;
    logic [2:0]  dest_q, dest_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  pos_q, pos_d;
    logic        ordy_q, ordy_d;

    // The one-hot destination field is not needed to match tags.
    logic unused_cdb_dest;
    assign unused_cdb_dest = ^cdb[CDB_DEST_MSB:CDB_DEST_LSB];

    assign bus_tag  = cdb_tag(cdb);
    assign bus_data = cdb_data(cdb);

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            rs_ula_entry #(
                .IDX(2'(gi))
            ) u_entry (
                .clock         (clock),
                .reset_n       (reset_n),
                .alloc         (alloc_vec[gi]),
                .alloc_op      (issue_op),
                .alloc_dest    (issue_dest),
                .alloc_qj_wait (issue_qj_wait),
                .alloc_qj      (issue_qj),
                .alloc_vj      (issue_vj),
                .alloc_qk_wait (issue_qk_wait),
                .alloc_qk      (issue_qk),
                .alloc_vk      (issue_vk),
                .cdb_valid     (cdb_valid),
                .cdb_tag_in    (bus_tag),
                .cdb_data_in   (bus_data),
                .dispatch      (disp_vec[gi]),
                .state_o       (ent_state[gi]),
                .op_o          (ent_op[gi]),
                .dest_o        (ent_dest[gi]),
                .vj_o          (ent_vj[gi]),
                .vk_o          (ent_vk[gi])
            );

            assign free_vec[gi]  = (ent_state[gi] == ST_FREE);
            assign ready_vec[gi] = (ent_state[gi] == ST_READY);
            assign alloc_vec[gi] = issue_accept && (issue_pos == 2'(gi));
            assign disp_vec[gi]  = any_ready && (disp_idx == 2'(gi));
        end
    endgenerate

    // Lowest-index search: walking downwards lets the smallest match win.
    always_comb begin
        issue_pos = 2'd0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                issue_pos = 2'(i);
            end
        end
    end

    always_comb begin
        disp_idx = 2'd0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                disp_idx = 2'(i);
            end
        end
    end

    assign issue_ready  = |free_vec;
    assign any_ready    = |ready_vec;
    assign issue_legal  = (issue_dest <= DEST_MAX) &&
                          ((issue_op == OP_ADD) || (issue_op == OP_SUB));
    assign issue_accept = issue_valid && issue_ready && issue_legal;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ry_q   <= 16'h0000;
            rz_q   <= 16'h0000;
            dest_q <= 3'b000;
            op_q   <= 3'b000;
            pos_q  <= 2'b00;
            ordy_q <= 1'b0;
        end else begin
            ry_q   <= ry_d;
            rz_q   <= rz_d;
            dest_q <= dest_d;
            op_q   <= op_d;
            pos_q  <= pos_d;
            ordy_q <= ordy_d;
        end
    end

    // Dispatch fields hold their last value when nothing is ready, so the
    // ULA only has to qualify them with the one-cycle strobe.
    always_comb begin
        ry_d   = ry_q;
        rz_d   = rz_q;
        dest_d = dest_q;
        op_d   = op_q;
        pos_d  = pos_q;
        ordy_d = 1'b0;
        if (any_ready) begin
            ry_d   = ent_vj[disp_idx];
            rz_d   = ent_vk[disp_idx];
            dest_d = ent_dest[disp_idx];
            op_d   = ent_op[disp_idx];
            pos_d  = disp_idx;
            ordy_d = 1'b1;
        end
    end

    assign RY_data        = ry_q;
    assign RZ_data        = rz_q;
    assign reg_dest       = dest_q;
    assign ULA_op         = op_q;
    assign RS_position    = pos_q;
    assign operands_ready = ordy_q;

endmodule

// File: doc/rs_ula.md
RS_ULA -- requirements
Module: rs_ula

Interface
REQ-001 clock  in  1  single system clock; all state updates on rising edge.
REQ-002 reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-003 issue_valid  in  1  issue stage presents a new ADD/SUB instruction.
REQ-004 issue_ready  out  1  combinational; 1 when any entry is FREE.
REQ-005 issue_pos  out  2  combinational; lowest-index FREE entry, i.e. the tag the issue stage records.
REQ-006 issue_op  in  3  3'b000 ADD, 3'b001 SUB.
REQ-007 issue_dest  in  3  destination register, R0..R2 only.
REQ-008 issue_qj_wait  in  1  1 = operand j pending on tag issue_qj; 0 = issue_vj valid.
REQ-009 issue_qj  in  3  producer tag {unit bit, RS position}.
REQ-010 issue_vj  in  16  operand j value.
REQ-011 issue_qk_wait / issue_qk / issue_vk  in  1/3/16  same as REQ-008..010 for operand k.
REQ-012 cdb  in  16  common data bus: [15:13] one-hot dest, [12:11] RS position, [10] unit (1 ULA, 0 ld/sd), [9:0] data.
REQ-013 cdb_valid  in  1  cdb carries a new broadcast this cycle.
REQ-014 RY_data  out  16  registered first operand to ULA.
REQ-015 RZ_data  out  16  registered second operand to ULA.
REQ-016 reg_dest  out  3  registered destination to ULA.
REQ-017 ULA_op  out  3  registered operation to ULA.
REQ-018 RS_position  out  2  registered entry index of dispatched instruction.
REQ-019 operands_ready  out  1  registered one-cycle dispatch strobe to ULA.

Function
REQ-020 Four entries, each state FREE, WAIT, READY or EXEC.
REQ-021 Issue fires when issue_valid && issue_ready; entry issue_pos is written: FREE->WAIT if any operand pending, else FREE->READY.
REQ-022 Issue with issue_dest > 3'b010 or issue_op > 3'b001 SHALL be dropped, no entry allocated.
REQ-023 CDB tag = {cdb[10], cdb[12:11]}; data = {6'b0, cdb[9:0]} (zero-extended to 16 bits).
REQ-024 When cdb_valid, every WAIT entry operand whose tag matches captures data and clears its wait bit; entry moves WAIT->READY on the edge its last operand clears.
REQ-025 Operand being issued in the same cycle as a matching cdb_valid broadcast SHALL capture cdb data (issue-time bypass).
REQ-026 Dispatch: each cycle, lowest-index READY entry -> EXEC, outputs loaded, operands_ready=1 for exactly that cycle; at most one dispatch per cycle.
REQ-027 With no READY entry, operands_ready=0 and other outputs hold last values.
REQ-028 Entry that became READY on an edge is eligible for dispatch starting the next cycle (no wakeup-to-dispatch bypass).
REQ-029 Free: cdb_valid && cdb[10]==1 && cdb[12:11]==entry index && entry in EXEC -> FREE; broadcasts matching a non-EXEC entry SHALL NOT free it.
REQ-030 issue_ready/issue_pos use pre-edge state; a slot freed on an edge is allocatable from the next cycle.
REQ-031 Full (4 non-FREE): issue_ready=0, issue_valid ignored, no state change from issue.

Reset
REQ-032 reset_n=0 at an edge: all entries FREE, wait bits and stored values cleared, operands_ready=0, RY_data=RZ_data=16'h0000, reg_dest=ULA_op=3'b000, RS_position=2'b00; overrides concurrent issue, CDB and dispatch.
REQ-033 Reset mid-operation discards all in-flight entries; later CDB broadcasts for discarded tags SHALL have no effect.

Structure
REQ-034 Shared package holds op encodings (ADD, SUB), entry state encoding, CDB field positions and the unit-bit value for ULA.
REQ-035 One sub-module, rs_ula_entry (single entry: state, operands, tag match); rs_ula instantiates four plus issue/dispatch priority logic.

Verification
REQ-036 Reset then issue ADD R1, vj=5, vk=3, no waits -> issue_pos=0, next cycle operands_ready=1, RY=5, RZ=3, ULA_op=000, reg_dest=001, RS_position=0.
REQ-037 Issue SUB with qj_wait on tag 3'b110 -> no dispatch; cdb_valid, cdb=16'b010_10_1_0000001010 -> RY_data=10 one cycle after WAIT->READY.
REQ-038 Fill 4 entries with waits -> issue_ready=0, 5th issue ignored; broadcast for EXEC entry 2 frees it, issue_pos=2 next cycle.
REQ-039 Issue with qj tag matching same-cycle cdb_valid broadcast -> entry READY immediately, RY_data = bypassed value.
REQ-040 Two entries READY on same edge -> entry 0 dispatches first, entry 1 next cycle; reset_n=0 mid-sequence -> all outputs at REQ-032 values, issue_ready=1, issue_pos=0.
